// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stage stall/hazard requests in, stall/flush/redirect/mdu status out.
// The controller takes the slave view; the pipeline datapath takes the master view.
interface pipe_ctrl_if;
   logic        if_stallreq_i;
   logic        id_stallreq_i;
   logic        ex_mdu_start_i;
   logic        ex_mdu_is_div_i;
   logic        mem_stallreq_i;
   logic        mem_exc_i;
   logic [31:0] mem_exc_pc_i;
   logic        mem_eret_i;
   logic [31:0] mem_epc_i;
   logic [4:0]  stall_o;
   logic [4:0]  flush_o;
   logic        redirect_en_o;
   logic [31:0] redirect_pc_o;
   logic        mdu_busy_o;
   logic        mdu_done_o;
   logic        mdu_cancel_o;

   modport master (
      output if_stallreq_i, id_stallreq_i, ex_mdu_start_i, ex_mdu_is_div_i,
             mem_stallreq_i, mem_exc_i, mem_exc_pc_i, mem_eret_i, mem_epc_i,
      input  stall_o, flush_o, redirect_en_o, redirect_pc_o,
             mdu_busy_o, mdu_done_o, mdu_cancel_o
   );

   modport slave (
      input  if_stallreq_i, id_stallreq_i, ex_mdu_start_i, ex_mdu_is_div_i,
             mem_stallreq_i, mem_exc_i, mem_exc_pc_i, mem_eret_i, mem_epc_i,
      output stall_o, flush_o, redirect_en_o, redirect_pc_o,
             mdu_busy_o, mdu_done_o, mdu_cancel_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencer: merges stall requests, times mul/div, holds PC redirects.
// Outputs are combinational in the request cycle; a redirect is held until fetch stops stalling.
module pipe_ctrl #(
   parameter int MUL_LAT = 2,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MDU, REDIR} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_redir_pc;

   logic        w_redir_req;
   logic [31:0] w_redir_tgt;
   logic        w_mdu_accept;
   logic        w_mdu_stall;
   logic        w_mdu_last;
   logic [4:0]  w_stall;
   logic [4:0]  w_flush;
   logic        w_redir_en;
   logic [31:0] w_redir_pc;
   logic        w_busy;
   logic        w_done;
   logic        w_cancel;

   assign w_redir_req  = (bus.mem_exc_i | bus.mem_eret_i) && (r_state != REDIR);
   assign w_redir_tgt  = bus.mem_exc_i ? bus.mem_exc_pc_i : bus.mem_epc_i;
   assign w_mdu_accept = (r_state == IDLE) && bus.ex_mdu_start_i && !bus.mem_stallreq_i && !w_redir_req;
   assign w_mdu_stall  = w_mdu_accept || ((r_state == MDU) && (r_cnt != '0));
   assign w_mdu_last   = (r_state == MDU) && (r_cnt == '0);

   always_comb begin
      w_stall    = 5'b00000;
      w_flush    = 5'b00000;
      w_redir_en = 1'b0;
      w_redir_pc = 32'h0;
      w_busy     = 1'b0;
      w_done     = 1'b0;
      w_cancel   = 1'b0;
      if (!rst) begin
         if (w_redir_req) begin
            w_flush    = 5'b11110;
            w_redir_en = 1'b1;
            w_redir_pc = w_redir_tgt;
            w_cancel   = (r_state == MDU);
         end else begin
            w_busy = w_mdu_stall;
            w_done = w_mdu_last;
            if (r_state == REDIR) begin
               w_redir_en = 1'b1;
               w_redir_pc = r_redir_pc;
               w_flush    = 5'b00010;
            end else if (bus.mem_stallreq_i) begin
               w_stall = 5'b01111;
               w_flush = 5'b10000;
            end else if (w_mdu_stall) begin
               w_stall = 5'b00111;
               w_flush = 5'b01000;
            end else if (bus.id_stallreq_i) begin
               w_stall = 5'b00011;
               w_flush = 5'b00100;
            end else if (bus.if_stallreq_i) begin
               w_stall = 5'b00001;
               w_flush = 5'b00010;
            end
         end
      end
   end

   assign bus.stall_o       = w_stall;
   assign bus.flush_o       = w_flush;
   assign bus.redirect_en_o = w_redir_en;
   assign bus.redirect_pc_o = w_redir_pc;
   assign bus.mdu_busy_o    = w_busy;
   assign bus.mdu_done_o    = w_done;
   assign bus.mdu_cancel_o  = w_cancel;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_redir_pc <= 32'h0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_redir_req) begin
                  if (bus.if_stallreq_i) begin
                     r_redir_pc <= w_redir_tgt;
                     r_state    <= REDIR;
                  end
               end else if (w_mdu_accept) begin
                  r_cnt   <= bus.ex_mdu_is_div_i ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                  r_state <= MDU;
               end
            end
            MDU: begin
               // An exception/eret aborts the mul/div and may itself need holding.
               if (w_redir_req) begin
                  r_cnt <= '0;
                  if (bus.if_stallreq_i) begin
                     r_redir_pc <= w_redir_tgt;
                     r_state    <= REDIR;
                  end else begin
                     r_state <= IDLE;
                  end
               end else if (r_cnt == '0) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            REDIR: begin
               if (!bus.if_stallreq_i) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected output vectors are queued per cycle and checked at negedge.
module tb_pipe_ctrl;
   typedef struct packed {
      logic [4:0]  stall;
      logic [4:0]  flush;
      logic        ren;
      logic [31:0] pc;
      logic        busy;
      logic        done;
      logic        cancel;
   } out_t;

   typedef struct {
      string tag;
      bit    sel;
      out_t  exp;
   } sb_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   sb_t  q[$];

   pipe_ctrl_if bus0 ();
   pipe_ctrl_if bus1 ();

   pipe_ctrl #(.MUL_LAT(2), .DIV_LAT(32)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   pipe_ctrl #(.MUL_LAT(1), .DIV_LAT(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;

   function automatic out_t mk(input logic [4:0] s, input logic [4:0] f, input logic ren,
                               input logic [31:0] pc, input logic busy, input logic done,
                               input logic cancel);
      out_t o;
      o.stall = s; o.flush = f; o.ren = ren; o.pc = pc;
      o.busy = busy; o.done = done; o.cancel = cancel;
      return o;
   endfunction

   localparam out_t ZERO = '0;

   function automatic out_t obs0();
      return mk(bus0.stall_o, bus0.flush_o, bus0.redirect_en_o, bus0.redirect_pc_o,
                bus0.mdu_busy_o, bus0.mdu_done_o, bus0.mdu_cancel_o);
   endfunction

   function automatic out_t obs1();
      return mk(bus1.stall_o, bus1.flush_o, bus1.redirect_en_o, bus1.redirect_pc_o,
                bus1.mdu_busy_o, bus1.mdu_done_o, bus1.mdu_cancel_o);
   endfunction

   // Inputs are already driven for this cycle; check at negedge, then advance past the edge.
   task automatic cyc(input string tag, input out_t e, input bit sel = 1'b0);
      sb_t  ent;
      out_t o;
      q.push_back('{tag: tag, sel: sel, exp: e});
      @(negedge clk);
      ent = q.pop_front();
      o = ent.sel ? obs1() : obs0();
      checks++;
      assert (o === ent.exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", ent.tag, o, ent.exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus0.if_stallreq_i = 0; bus0.id_stallreq_i = 0; bus0.ex_mdu_start_i = 0;
      bus0.ex_mdu_is_div_i = 0; bus0.mem_stallreq_i = 0; bus0.mem_exc_i = 0;
      bus0.mem_exc_pc_i = 0; bus0.mem_eret_i = 0; bus0.mem_epc_i = 0;
      bus1.if_stallreq_i = 0; bus1.id_stallreq_i = 0; bus1.ex_mdu_start_i = 0;
      bus1.ex_mdu_is_div_i = 0; bus1.mem_stallreq_i = 0; bus1.mem_exc_i = 0;
      bus1.mem_exc_pc_i = 0; bus1.mem_eret_i = 0; bus1.mem_epc_i = 0;
   endtask

   initial begin
      out_t mdu_stl, redir_a;
      mdu_stl = mk(5'b00111, 5'b01000, 0, 0, 1, 0, 0);
      clr();
      rst = 1'b1;
      @(posedge clk); #1;
      cyc("rst_quiet", ZERO);
      bus0.mem_exc_i = 1; bus0.mem_exc_pc_i = 32'h1234_5678; bus0.ex_mdu_start_i = 1;
      bus0.if_stallreq_i = 1; bus0.mem_stallreq_i = 1;
      cyc("rst_active_inputs", ZERO);
      clr(); rst = 1'b0;
      cyc("idle", ZERO);

      // MEM stall dominates the load-use stall, then load-use takes over
      bus0.mem_stallreq_i = 1; bus0.id_stallreq_i = 1;
      for (int i = 0; i < 3; i++) cyc("mem_stall", mk(5'b01111, 5'b10000, 0, 0, 0, 0, 0));
      bus0.mem_stallreq_i = 0;
      for (int i = 0; i < 2; i++) cyc("id_stall", mk(5'b00011, 5'b00100, 0, 0, 0, 0, 0));
      bus0.id_stallreq_i = 0; bus0.if_stallreq_i = 1;
      cyc("if_stall", mk(5'b00001, 5'b00010, 0, 0, 0, 0, 0));
      bus0.if_stallreq_i = 0;

      // Divide: 32 stalled cycles, done at cycle 32; a MEM stall at cycle 5 does not stretch it
      bus0.ex_mdu_start_i = 1; bus0.ex_mdu_is_div_i = 1;
      cyc("div_c0", mdu_stl);
      bus0.ex_mdu_start_i = 0;
      for (int c = 1; c < 32; c++) begin
         bus0.mem_stallreq_i = (c == 5);
         if (c == 5) cyc("div_memstall", mk(5'b01111, 5'b10000, 0, 0, 1, 0, 0));
         else        cyc("div_busy", mdu_stl);
      end
      bus0.mem_stallreq_i = 0;
      cyc("div_done", mk(0, 0, 0, 0, 0, 1, 0));
      cyc("div_after", ZERO);

      // Multiply with start first blocked by a MEM stall
      bus0.ex_mdu_start_i = 1; bus0.ex_mdu_is_div_i = 0; bus0.mem_stallreq_i = 1;
      cyc("mul_start_blocked", mk(5'b01111, 5'b10000, 0, 0, 0, 0, 0));
      bus0.mem_stallreq_i = 0;
      cyc("mul_c0", mdu_stl);
      bus0.ex_mdu_start_i = 0;
      cyc("mul_c1", mdu_stl);
      cyc("mul_done", mk(0, 0, 0, 0, 0, 1, 0));

      // MUL_LAT=1 instance: single stalled cycle
      bus1.ex_mdu_start_i = 1;
      cyc("mul1_c0", mdu_stl, 1'b1);
      bus1.ex_mdu_start_i = 0;
      cyc("mul1_done", mk(0, 0, 0, 0, 0, 1, 0), 1'b1);
      cyc("mul1_after", ZERO, 1'b1);

      // Exception mid-divide with fetch ready: cancel, straight back to IDLE
      bus0.ex_mdu_start_i = 1; bus0.ex_mdu_is_div_i = 1;
      cyc("exdiv_c0", mdu_stl);
      bus0.ex_mdu_start_i = 0;
      for (int c = 1; c < 10; c++) cyc("exdiv_busy", mdu_stl);
      bus0.mem_exc_i = 1; bus0.mem_exc_pc_i = 32'hBFC0_0380;
      cyc("exdiv_cancel", mk(0, 5'b11110, 1, 32'hBFC0_0380, 0, 0, 1));
      clr();
      for (int c = 11; c < 14; c++) cyc("exdiv_idle", ZERO);

      // eret while fetch stalls: redirect held 5 cycles, later exc/start ignored
      redir_a = mk(0, 5'b00010, 1, 32'h8000_1234, 0, 0, 0);
      bus0.mem_eret_i = 1; bus0.mem_epc_i = 32'h8000_1234; bus0.if_stallreq_i = 1;
      cyc("eret_c0", mk(0, 5'b11110, 1, 32'h8000_1234, 0, 0, 0));
      bus0.mem_eret_i = 0;
      cyc("redir_hold", redir_a);
      bus0.mem_exc_i = 1; bus0.mem_exc_pc_i = 32'hDEAD_0000; bus0.ex_mdu_start_i = 1;
      bus0.mem_stallreq_i = 1;
      cyc("redir_ignore", redir_a);
      bus0.mem_exc_i = 0; bus0.ex_mdu_start_i = 0; bus0.mem_stallreq_i = 0;
      cyc("redir_hold", redir_a);
      bus0.if_stallreq_i = 0;
      cyc("redir_release", redir_a);
      cyc("redir_idle", ZERO);

      // Exception mid-multiply while fetch stalls: cancel then held redirect
      bus0.ex_mdu_start_i = 1;
      cyc("exmul_c0", mdu_stl);
      bus0.ex_mdu_start_i = 0; bus0.mem_exc_i = 1; bus0.mem_exc_pc_i = 32'h0000_0180;
      bus0.if_stallreq_i = 1;
      cyc("exmul_cancel", mk(0, 5'b11110, 1, 32'h0000_0180, 0, 0, 1));
      clr();
      cyc("exmul_redir", mk(0, 5'b00010, 1, 32'h0000_0180, 0, 0, 0));
      cyc("exmul_idle", ZERO);

      // Exception beats eret and MEM stall
      bus0.mem_exc_i = 1; bus0.mem_exc_pc_i = 32'hBFC0_0200;
      bus0.mem_eret_i = 1; bus0.mem_epc_i = 32'h8000_0040; bus0.mem_stallreq_i = 1;
      cyc("simul_exc", mk(0, 5'b11110, 1, 32'hBFC0_0200, 0, 0, 0));
      clr();
      cyc("simul_after", ZERO);

      // Reset in the middle of a divide
      bus0.ex_mdu_start_i = 1; bus0.ex_mdu_is_div_i = 1;
      cyc("rstdiv_c0", mdu_stl);
      bus0.ex_mdu_start_i = 0;
      cyc("rstdiv_c1", mdu_stl);
      rst = 1'b1;
      cyc("rstdiv_rst", ZERO);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) cyc("rstdiv_idle", ZERO);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB). It merges stall requests from IF, ID, EX and MEM into per-register stall and flush vectors, and drives the decoder's id_stall_i and id_flush_i. It times multi-cycle mul/div in EX with a countdown FSM. It issues PC redirects for exceptions and eret, holding each redirect until the fetch stage can accept it.

Parameters:
MUL_LAT, 2, EX stall cycles for mult/multu (>=1)
DIV_LAT, 32, EX stall cycles for div/divu (>=1)
CNT_W, $clog2(DIV_LAT+1), countdown width (derived)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
if_stallreq_i  in  1  icache miss; fetch cannot accept a new PC
id_stallreq_i  in  1  load-use hazard (decoder id_stallreq_o)
ex_mdu_start_i  in  1  EX holds an unstarted mul/div; sampled only in IDLE
ex_mdu_is_div_i  in  1  1=div/divu, 0=mult/multu; valid with start
mem_stallreq_i  in  1  dcache miss in MEM
mem_exc_i  in  1  exception committed in MEM
mem_exc_pc_i  in  32  exception handler address
mem_eret_i  in  1  eret in MEM
mem_epc_i  in  32  EPC value
stall_o  out  5  hold: b0 PC, b1 IF/ID, b2 ID/EX, b3 EX/MEM, b4 MEM/WB
flush_o  out  5  load bubble at next edge, same bit map; b0 always 0
redirect_en_o  out  1  fetch loads redirect_pc_o
redirect_pc_o  out  32  redirect target
mdu_busy_o  out  1  mul/div in progress
mdu_done_o  out  1  1-cycle pulse; mul/div result valid, EX advances
mdu_cancel_o  out  1  1-cycle pulse; mul/div aborted by exception/eret

Behaviour:
- FSM states: IDLE, MDU, REDIR. Registers: state, cnt[CNT_W], redir_pc_q[32].
- Reset: state=IDLE, cnt=0, redir_pc_q=0. While rst is high, every output is 0.
- Outputs are combinational from state, cnt and inputs. Exactly one row below applies per cycle, in priority order:
  1. Redirect (mem_exc_i|mem_eret_i, state!=REDIR): stall=00000, flush=11110, redirect_en_o=1.
     - redirect_pc_o = mem_exc_pc_i if mem_exc_i, else mem_epc_i. Exception beats eret.
  2. REDIR state: redirect_en_o=1, redirect_pc_o=redir_pc_q, stall=00000, flush=00010.
  3. mem_stallreq_i: stall=01111, flush=10000.
  4. MDU stall (ex_mdu_start_i accepted in IDLE, or state MDU with cnt!=0): stall=00111, flush=01000.
  5. id_stallreq_i: stall=00011, flush=00100.
  6. if_stallreq_i: stall=00001, flush=00010.
  7. Otherwise: stall=0, flush=0.
- IDLE transitions:
  - Row 1 with if_stallreq_i=1: redir_pc_q <= selected target; go REDIR.
  - Row 1 with if_stallreq_i=0: stay IDLE.
  - ex_mdu_start_i & ~mem_stallreq_i & no row 1: cnt <= (is_div ? DIV_LAT : MUL_LAT) - 1; go MDU. mdu_busy_o=1 this cycle.
  - Start with mem_stallreq_i=1: ignored; EX reasserts start next cycle.
- MDU state:
  - cnt!=0: mdu_busy_o=1, cnt decrements each cycle regardless of mem_stallreq_i.
  - cnt==0: mdu_done_o=1, mdu_busy_o=0, MDU stall released, go IDLE.
  - Net effect: start at cycle 0 gives LAT stalled cycles (0..LAT-1) and done at cycle LAT.
- Exception/eret in MDU: mdu_cancel_o=1, no done, cnt <= 0. Go REDIR if if_stallreq_i, else IDLE.
- REDIR state:
  - Leave to IDLE in the first cycle if_stallreq_i=0. redirect_en_o is still 1 in that cycle; fetch takes the PC then.
  - mem_exc_i, mem_eret_i and ex_mdu_start_i are ignored; the pipeline is empty.
- Mid-operation reset returns to IDLE and drops any pending redirect or mul/div.

Test Plan:
- MEM stall: mem_stallreq_i=1 for 3 cycles with id_stallreq_i=1 → stall_o=01111, flush_o=10000 for 3 cycles; then 00011/00100 while id_stallreq_i stays high.
- Division: ex_mdu_start_i=1, is_div=1 at cycle 0 → stall_o=00111 and mdu_busy_o=1 cycles 0..31; mdu_done_o=1, stall_o=0 at cycle 32.
- Multiply with LAT edge: MUL_LAT=1, start at cycle 0 → stalled cycle 0 only, mdu_done_o at cycle 1.
- Exception mid-divide: start at 0, mem_exc_i at cycle 10 with pc=0xBFC00380, if_stallreq_i=0 → flush_o=11110, redirect_en_o=1 with pc 0xBFC00380, mdu_cancel_o=1; no mdu_done_o; IDLE at 11.
- Held redirect: mem_eret_i=1, epc=0x80001234, if_stallreq_i=1 for 4 cycles → redirect_en_o=1 with 0x80001234 for 5 cycles, flush_o=00010 in REDIR; IDLE after if_stallreq_i falls.
- Simultaneous events: mem_exc_i & mem_eret_i & mem_stallreq_i → exception target chosen, stall_o=0. Reset asserted in MDU → all outputs 0; IDLE after release.
